uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
UART transmit path, the counterpart of the receive-side deserializer. Accepts a parallel byte with a single-cycle valid strobe and emits one serial frame on TX_OUT: start bit, data LSB first, optional parity, stop bit. CLK is the TX bit clock, so one frame bit is emitted per cycle; baud division happens upstream. Sits between the system TX FIFO/controller and the UART pin.

Parameters:
DATA_WIDTH, 8, data bits per frame (supported range 5..9)

Ports:
CLK  in  1  TX bit clock, rising edge
RST  in  1  asynchronous, active-high reset
P_DATA  in  DATA_WIDTH  parallel data to send
DATA_VALID  in  1  request strobe; sampled only when the block can accept
PAR_EN  in  1  1 = insert parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
TX_OUT  out  1  serial line; idles high; registered
BUSY  out  1  high for every cycle a frame bit is on TX_OUT; registered

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset (async, any time): TX_OUT=1, BUSY=0, state=IDLE, bit counter=0, shadow registers cleared. Reset mid-frame aborts the frame immediately. No partial bits resume after release.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept condition: DATA_VALID=1 while state is IDLE or STOP. On accept, latch P_DATA, PAR_EN and PAR_TYP into shadow registers and compute parity from the latched data.
- Latency: the start bit appears on TX_OUT in the cycle after the accepting edge. Bits are registered, so TX_OUT never glitches.
- IDLE: TX_OUT=1, BUSY=0. Go to START on accept.
- START: TX_OUT=0, BUSY=1, bit counter cleared. Next state is DATA.
- DATA: TX_OUT=shadow[bit_cnt], sent LSB first, with bit_cnt incrementing 0..DATA_WIDTH-1. After the last bit, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: TX_OUT = XOR-reduce(shadow) XOR latched PAR_TYP. Next state is STOP.
- STOP: TX_OUT=1, BUSY=1. If accept occurs this cycle, go to START (back-to-back, no idle gap, BUSY stays high). Otherwise go to IDLE.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity.
- DATA_VALID in START, DATA or PARITY: ignored, not queued, no side effect. Upstream must hold or re-present the request.
- Changes on P_DATA, PAR_EN or PAR_TYP after accept: no effect on the current frame.
- bit_cnt width is clog2(DATA_WIDTH). It never wraps inside DATA. The exit test is bit_cnt==DATA_WIDTH-1.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - parity constants PAR_EVEN=1'b0, PAR_ODD=1'b1
  - line levels IDLE_LVL=1'b1, START_LVL=1'b0, STOP_LVL=1'b1
- Sub-module: uart_tx_serializer holds the shadow register, bit counter and the done flag. The FSM, parity calc and output mux stay in the top module.

Test Plan:
- Reset: assert RST mid-simulation with no clock edge -> TX_OUT=1 and BUSY=0 immediately. Hold low 5 cycles with DATA_VALID=0 -> TX_OUT stays 1.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, DATA_VALID pulsed 1 cycle -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 (parity 0). BUSY high exactly 11 cycles, then TX_OUT=1, BUSY=0.
- P_DATA=0x03, PAR_EN=1, PAR_TYP=1 -> parity bit 1. Frame 0,1,1,0,0,0,0,0,0,1,1.
- P_DATA=0xFF, PAR_EN=0 -> frame 0,1,1,1,1,1,1,1,1,1 (10 cycles). Pulse DATA_VALID with 0x00 during data bit 4 -> ignored, TX_OUT returns to idle after the stop bit.
- Back-to-back: send 0x55 (no parity), present 0x0F with DATA_VALID=1 in the stop cycle -> next cycle is the start bit of the 0x0F frame, BUSY never drops, 20 contiguous frame bits.
- Reset mid-frame: assert RST during data bit 3 of 0xA5 -> TX_OUT=1 and BUSY=0 at once. After release, DATA_VALID with 0x3C -> clean frame 0,0,0,1,1,1,1,0,0,(parity if enabled),1.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   - state_e      : frame state machine encoding
//   - PAR_EVEN/ODD : parity type selector values
//   - *_LVL        : serial line levels for idle, start and stop bits
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// Holds the latched data byte and the data-bit counter for one frame.
// Ports:
//   clk_i      : TX bit clock
//   rst_i      : asynchronous active-high reset
//   load_i     : latch data_i and restart the counter (frame accepted)
//   data_i     : parallel data to latch
//   cnt_clr_i  : clear the bit counter
//   cnt_inc_i  : advance the bit counter by one
//   nxt_bit_o  : data bit addressed by the counter's next value, so the
//                caller can register it and have it on the line next cycle
//   done_o     : counter currently addresses the last data bit
// ----------------------------------------------------------------------------
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  cnt_clr_i,
  input  logic                  cnt_inc_i,
  output logic                  nxt_bit_o,
  output logic                  done_o
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Next-state logic for the shadow register and bit counter.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      shadow_d = data_i;
      cnt_d    = '0;
    end else if (cnt_clr_i) begin
      cnt_d    = '0;
    end else if (cnt_inc_i) begin
      cnt_d    = cnt_q + CNT_W'(1);
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Shadow register and bit counter storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  // The caller only increments while done_o is low, so cnt_d stays in range.
  assign nxt_bit_o = shadow_q[cnt_d];
  assign done_o    = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule : uart_tx_serializer

// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame
// UART transmitter: one frame bit per CLK cycle.
// Frame: start (0), DATA_WIDTH data bits LSB first, optional parity, stop (1).
// Ports:
//   CLK        : TX bit clock, rising edge
//   RST        : asynchronous active-high reset (aborts any frame)
//   P_DATA     : parallel data to send
//   DATA_VALID : request strobe, accepted only in IDLE or STOP
//   PAR_EN     : 1 = insert parity bit
//   PAR_TYP    : 0 = even, 1 = odd parity
//   TX_OUT     : registered serial line, idles high
//   BUSY       : registered, high while a frame bit is on TX_OUT
// ----------------------------------------------------------------------------
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  state_e state_q, state_d;
  logic   tx_q, tx_d;
  logic   busy_q, busy_d;
  logic   par_en_q, par_en_d;
  logic   parity_q, parity_d;

  logic   accept_s;
  logic   cnt_clr_s;
  logic   cnt_inc_s;
  logic   nxt_bit_s;
  logic   done_s;

  // Parity bit for a data word: even parity makes the total count of ones even.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  assign accept_s = DATA_VALID && ((state_q == IDLE) || (state_q == STOP));

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk_i     (CLK),
    .rst_i     (RST),
    .load_i    (accept_s),
    .data_i    (P_DATA),
    .cnt_clr_i (cnt_clr_s),
    .cnt_inc_i (cnt_inc_s),
    .nxt_bit_o (nxt_bit_s),
    .done_o    (done_s)
  );

  // Frame sequencing and latching of the per-frame parity settings.
  always_comb begin
    state_d   = state_q;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    par_en_d  = par_en_q;
    parity_d  = parity_q;

    if (accept_s) begin
      par_en_d = PAR_EN;
      parity_d = calc_parity(P_DATA, PAR_TYP);
    end else begin
      par_en_d = par_en_q;
      parity_d = parity_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        state_d   = DATA;
        cnt_clr_s = 1'b1;
      end
      DATA: begin
        if (done_s) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          state_d   = DATA;
          cnt_inc_s = 1'b1;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        // Back-to-back frames go straight to START with no idle gap.
        if (accept_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level for the state about to be entered, so TX_OUT is glitch-free.
  always_comb begin
    tx_d   = IDLE_LVL;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    tx_d = IDLE_LVL;
      START:   tx_d = START_LVL;
      DATA:    tx_d = nxt_bit_s;
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = STOP_LVL;
      default: tx_d = IDLE_LVL;
    endcase
  end

  // State, output and parity-setting registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule : uart_tx_frame
